// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between the interconnect slave port and the SRAM responder.
interface axi_sram_slave_if #(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
) ();
    localparam int unsigned STRB_W = DATA_W / 8;

    // write address channel
    logic [ID_W-1:0]   AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [LEN_W-1:0]  AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              AWVALID;
    logic              AWREADY;
    // write data channel
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    // write response channel
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    // read address channel
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [LEN_W-1:0]  ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    // read data channel
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 responder backed by a single-port synchronous SRAM; one burst at a time.
module axi_sram_slave #(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned MEM_AW = 14
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axi_sram_slave_if.slave   axi,
    output logic              CEB,
    output logic              WEB,
    output logic [DATA_W-1:0] BWEB,
    output logic [MEM_AW-1:0] A,
    output logic [DATA_W-1:0] DI,
    input  logic [DATA_W-1:0] DO
);
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t            state_q, state_n;
    logic [ID_W-1:0]   id_q, id_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [LEN_W-1:0]  len_q, len_n;
    logic [LEN_W-1:0]  beat_q, beat_n;
    logic              fixed_q, fixed_n;
    logic              err_q, err_n;

    logic awready, wready, bvalid, arready, rvalid, rlast;
    logic last_beat;
    logic [ADDR_W-1:0] addr_step;

    assign last_beat = (beat_q == len_q);
    // FIXED bursts stay on one word; everything else (incl. WRAP) increments
    assign addr_step = fixed_q ? addr_q : addr_q + ADDR_W'(4);

    // State and burst-context registers
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            fixed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            id_q    <= id_n;
            addr_q  <= addr_n;
            len_q   <= len_n;
            beat_q  <= beat_n;
            fixed_q <= fixed_n;
            err_q   <= err_n;
        end
    end

    // Next-state, burst bookkeeping, handshake and SRAM strobes
    always_comb begin
        state_n = state_q;
        id_n    = id_q;
        addr_n  = addr_q;
        len_n   = len_q;
        beat_n  = beat_q;
        fixed_n = fixed_q;
        err_n   = err_q;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        CEB     = 1'b1;
        WEB     = 1'b1;
        BWEB    = '1;
        A       = addr_q[MEM_AW+1:2];
        DI      = '0;

        unique case (state_q)
            IDLE: begin
                arready = 1'b1;
                awready = ~axi.ARVALID;
                if (axi.ARVALID) begin
                    id_n    = axi.ARID;
                    addr_n  = axi.ARADDR;
                    len_n   = axi.ARLEN;
                    fixed_n = (axi.ARBURST == 2'b00);
                    beat_n  = '0;
                    state_n = RD_REQ;
                end else if (axi.AWVALID) begin
                    id_n    = axi.AWID;
                    addr_n  = axi.AWADDR;
                    len_n   = axi.AWLEN;
                    fixed_n = (axi.AWBURST == 2'b00);
                    beat_n  = '0;
                    err_n   = 1'b0;
                    state_n = WR_DATA;
                end
            end
            RD_REQ: begin
                CEB     = 1'b0;
                WEB     = 1'b1;
                state_n = RD_DATA;
            end
            RD_DATA: begin
                rvalid = 1'b1;
                rlast  = last_beat;
                if (axi.RREADY) begin
                    if (last_beat) begin
                        state_n = IDLE;
                    end else begin
                        beat_n  = beat_q + LEN_W'(1);
                        addr_n  = addr_step;
                        state_n = RD_REQ;
                    end
                end
            end
            WR_DATA: begin
                wready = 1'b1;
                if (axi.WVALID) begin
                    CEB = 1'b0;
                    WEB = 1'b0;
                    DI  = axi.WDATA;
                    for (int i = 0; i < STRB_W; i++) begin
                        BWEB[8*i +: 8] = {8{~axi.WSTRB[i]}};
                    end
                    if (axi.WLAST != last_beat) begin
                        err_n = 1'b1;
                    end
                    if (last_beat) begin
                        state_n = WR_RESP;
                    end else begin
                        beat_n = beat_q + LEN_W'(1);
                        addr_n = addr_step;
                    end
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (axi.BREADY) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Reset cycle: bus is quiet and the SRAM is deselected
        if (!ARESETn) begin
            awready = 1'b0;
            wready  = 1'b0;
            bvalid  = 1'b0;
            arready = 1'b0;
            rvalid  = 1'b0;
            rlast   = 1'b0;
            CEB     = 1'b1;
            WEB     = 1'b1;
            BWEB    = '1;
        end
    end

    // AXI outputs; read data is passed straight from the SRAM, which holds DO while CEB=1
    assign axi.AWREADY = awready;
    assign axi.WREADY  = wready;
    assign axi.BVALID  = bvalid;
    assign axi.BID     = id_q;
    assign axi.BRESP   = err_q ? 2'b10 : 2'b00;
    assign axi.ARREADY = arready;
    assign axi.RVALID  = rvalid;
    assign axi.RLAST   = rlast;
    assign axi.RID     = id_q;
    assign axi.RDATA   = DO;
    assign axi.RRESP   = 2'b00;

    // Size fields and sub-word / out-of-macro address bits carry no meaning here
    logic unused_bits;
    assign unused_bits = &{1'b0, axi.AWSIZE, axi.ARSIZE, addr_q[1:0],
                           addr_q[ADDR_W-1:MEM_AW+2]};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave with a behavioural SRAM macro.
module tb_axi_sram_slave;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned MEM_AW = 14;

    logic              ACLK;
    logic              ARESETn;
    logic              CEB;
    logic              WEB;
    logic [DATA_W-1:0] BWEB;
    logic [MEM_AW-1:0] A;
    logic [DATA_W-1:0] DI;
    logic [DATA_W-1:0] DO;

    int errors = 0;
    int checks = 0;

    axi_sram_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

    axi_sram_slave #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MEM_AW(MEM_AW)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .axi(bus),
        .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Behavioural single-port SRAM: registered read, masked write
    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];
    initial DO = '0;
    always @(posedge ACLK) begin
        if (!CEB) begin
            if (!WEB) mem[A] <= (mem[A] & BWEB) | (DI & ~BWEB);
            else      DO <= mem[A];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_aw(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
        bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWBURST = burst;
        bus.AWSIZE = 3'd2; bus.AWVALID = 1'b1;
        #1;
        chk("aw_ready", 32'(bus.AWREADY), 32'd1);
        next_cyc();
        bus.AWVALID = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        input logic [13:0] exp_a, input logic [31:0] exp_bweb);
        bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
        #1;
        chk("w_ready", 32'(bus.WREADY), 32'd1);
        chk("w_ceb", 32'(CEB), 32'd0);
        chk("w_web", 32'(WEB), 32'd0);
        chk("w_addr", 32'(A), 32'(exp_a));
        chk("w_bweb", BWEB, exp_bweb);
        chk("w_di", DI, data);
        next_cyc();
        bus.WVALID = 1'b0;
    endtask

    task automatic do_b(input logic [7:0] exp_id, input logic [1:0] exp_resp);
        bus.BREADY = 1'b1;
        #1;
        chk("b_valid", 32'(bus.BVALID), 32'd1);
        chk("b_id", 32'(bus.BID), 32'(exp_id));
        chk("b_resp", 32'(bus.BRESP), 32'(exp_resp));
        next_cyc();
        bus.BREADY = 1'b0;
    endtask

    task automatic do_ar(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
        bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARBURST = burst;
        bus.ARSIZE = 3'd2; bus.ARVALID = 1'b1;
        #1;
        chk("ar_ready", 32'(bus.ARREADY), 32'd1);
        next_cyc();
        bus.ARVALID = 1'b0;
    endtask

    // One read beat: SRAM request cycle, optional stall cycle, then R handshake
    task automatic rd_beat(input logic [13:0] exp_a, input logic [31:0] exp_data,
                           input logic [7:0] exp_id, input logic exp_last, input logic stall);
        #1;
        chk("rq_rvalid", 32'(bus.RVALID), 32'd0);
        chk("rq_ceb", 32'(CEB), 32'd0);
        chk("rq_web", 32'(WEB), 32'd1);
        chk("rq_addr", 32'(A), 32'(exp_a));
        chk("rq_arready", 32'(bus.ARREADY), 32'd0);
        next_cyc();
        if (stall) begin
            bus.RREADY = 1'b0;
            #1;
            chk("rs_rvalid", 32'(bus.RVALID), 32'd1);
            chk("rs_rdata", bus.RDATA, exp_data);
            chk("rs_rlast", 32'(bus.RLAST), 32'(exp_last));
            next_cyc();
        end
        bus.RREADY = 1'b1;
        #1;
        chk("r_rvalid", 32'(bus.RVALID), 32'd1);
        chk("r_rdata", bus.RDATA, exp_data);
        chk("r_rid", 32'(bus.RID), 32'(exp_id));
        chk("r_rlast", 32'(bus.RLAST), 32'(exp_last));
        chk("r_rresp", 32'(bus.RRESP), 32'd0);
        chk("r_ceb", 32'(CEB), 32'd1);
        next_cyc();
        bus.RREADY = 1'b0;
    endtask

    initial begin
        ARESETn = 1'b0;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
        bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

        // reset state
        next_cyc();
        next_cyc();
        chk("rst_arready", 32'(bus.ARREADY), 32'd0);
        chk("rst_awready", 32'(bus.AWREADY), 32'd0);
        chk("rst_rvalid", 32'(bus.RVALID), 32'd0);
        chk("rst_bvalid", 32'(bus.BVALID), 32'd0);
        chk("rst_ceb", 32'(CEB), 32'd1);
        chk("rst_web", 32'(WEB), 32'd1);
        chk("rst_bweb", BWEB, 32'hFFFF_FFFF);
        ARESETn = 1'b1;
        #1;
        chk("idle_arready", 32'(bus.ARREADY), 32'd1);
        chk("idle_awready", 32'(bus.AWREADY), 32'd1);
        chk("idle_ceb", 32'(CEB), 32'd1);
        next_cyc();

        // single write then read
        do_aw(8'h5A, 32'h0000_0010, 4'd0, 2'b01);
        do_w(32'hDEAD_BEEF, 4'hF, 1'b1, 14'h0004, 32'h0000_0000);
        do_b(8'h5A, 2'b00);
        chk("mem_single", mem[4], 32'hDEAD_BEEF);
        do_ar(8'hA5, 32'h0000_0010, 4'd0, 2'b01);
        rd_beat(14'h0004, 32'hDEAD_BEEF, 8'hA5, 1'b1, 1'b0);

        // INCR burst of 4
        do_aw(8'h11, 32'h0000_0100, 4'd3, 2'b01);
        do_w(32'd1, 4'hF, 1'b0, 14'h0040, 32'h0);
        do_w(32'd2, 4'hF, 1'b0, 14'h0041, 32'h0);
        do_w(32'd3, 4'hF, 1'b0, 14'h0042, 32'h0);
        do_w(32'd4, 4'hF, 1'b1, 14'h0043, 32'h0);
        do_b(8'h11, 2'b00);
        do_ar(8'h22, 32'h0000_0100, 4'd3, 2'b01);
        rd_beat(14'h0040, 32'd1, 8'h22, 1'b0, 1'b0);
        rd_beat(14'h0041, 32'd2, 8'h22, 1'b0, 1'b1);
        rd_beat(14'h0042, 32'd3, 8'h22, 1'b0, 1'b0);
        rd_beat(14'h0043, 32'd4, 8'h22, 1'b1, 1'b1);

        // byte strobes
        do_aw(8'h01, 32'h0000_0020, 4'd0, 2'b01);
        do_w(32'hFFFF_FFFF, 4'hF, 1'b1, 14'h0008, 32'h0);
        do_b(8'h01, 2'b00);
        do_aw(8'h02, 32'h0000_0020, 4'd0, 2'b01);
        do_w(32'h1234_5678, 4'b0101, 1'b1, 14'h0008, 32'hFF00_FF00);
        do_b(8'h02, 2'b00);
        do_ar(8'h03, 32'h0000_0020, 4'd0, 2'b01);
        rd_beat(14'h0008, 32'hFF34_FF78, 8'h03, 1'b1, 1'b0);

        // simultaneous AR/AW: read wins, write waits for IDLE
        bus.ARID = 8'h44; bus.ARADDR = 32'h10; bus.ARLEN = 4'd0; bus.ARBURST = 2'b01;
        bus.ARVALID = 1'b1;
        bus.AWID = 8'h55; bus.AWADDR = 32'h30; bus.AWLEN = 4'd0; bus.AWBURST = 2'b01;
        bus.AWVALID = 1'b1;
        #1;
        chk("sim_arready", 32'(bus.ARREADY), 32'd1);
        chk("sim_awready", 32'(bus.AWREADY), 32'd0);
        next_cyc();
        bus.ARVALID = 1'b0;
        #1;
        chk("sim_awready_req", 32'(bus.AWREADY), 32'd0);
        next_cyc();
        bus.RREADY = 1'b1;
        #1;
        chk("sim_rdata", bus.RDATA, 32'hDEAD_BEEF);
        chk("sim_awready_data", 32'(bus.AWREADY), 32'd0);
        next_cyc();
        bus.RREADY = 1'b0;
        #1;
        chk("sim_awready_idle", 32'(bus.AWREADY), 32'd1);
        next_cyc();
        bus.AWVALID = 1'b0;
        do_w(32'hCAFE_0030, 4'hF, 1'b1, 14'h000C, 32'h0);
        do_b(8'h55, 2'b00);

        // WLAST early: both beats still written, SLVERR
        do_aw(8'h66, 32'h0000_0050, 4'd1, 2'b01);
        do_w(32'hA0A0_0001, 4'hF, 1'b1, 14'h0014, 32'h0);
        do_w(32'hA0A0_0002, 4'hF, 1'b1, 14'h0015, 32'h0);
        do_b(8'h66, 2'b10);
        chk("mem_err0", mem[14'h14], 32'hA0A0_0001);
        chk("mem_err1", mem[14'h15], 32'hA0A0_0002);

        // FIXED burst: every beat hits the same word
        do_aw(8'h77, 32'h0000_0040, 4'd2, 2'b00);
        do_w(32'h0000_00F1, 4'hF, 1'b0, 14'h0010, 32'h0);
        do_w(32'h0000_00F2, 4'hF, 1'b0, 14'h0010, 32'h0);
        do_w(32'h0000_00F3, 4'hF, 1'b1, 14'h0010, 32'h0);
        do_b(8'h77, 2'b00);
        do_ar(8'h78, 32'h0000_0040, 4'd0, 2'b00);
        rd_beat(14'h0010, 32'h0000_00F3, 8'h78, 1'b1, 1'b0);

        // SRAM word address wraps at the top of the macro
        do_aw(8'h88, 32'h0001_FFFC, 4'd1, 2'b01);
        do_w(32'h0000_0077, 4'hF, 1'b0, 14'h3FFF, 32'h0);
        do_w(32'h0000_0088, 4'hF, 1'b1, 14'h0000, 32'h0);
        do_b(8'h88, 2'b00);
        do_ar(8'h89, 32'h0001_FFFC, 4'd1, 2'b01);
        rd_beat(14'h3FFF, 32'h0000_0077, 8'h89, 1'b0, 1'b0);
        rd_beat(14'h0000, 32'h0000_0088, 8'h89, 1'b1, 1'b0);

        // reset during beat 1 of a 4-beat read
        do_ar(8'h99, 32'h0000_0100, 4'd3, 2'b01);
        rd_beat(14'h0040, 32'd1, 8'h99, 1'b0, 1'b0);
        #1;
        chk("mr_rq_addr", 32'(A), 32'h41);
        next_cyc();
        #1;
        chk("mr_rvalid_pre", 32'(bus.RVALID), 32'd1);
        ARESETn = 1'b0;
        #1;
        chk("mr_rvalid_rst", 32'(bus.RVALID), 32'd0);
        next_cyc();
        ARESETn = 1'b1;
        #1;
        chk("mr_rvalid_after", 32'(bus.RVALID), 32'd0);
        chk("mr_arready_after", 32'(bus.ARREADY), 32'd1);
        chk("mr_ceb_after", 32'(CEB), 32'd1);
        next_cyc();
        chk("mr_rvalid_idle", 32'(bus.RVALID), 32'd0);
        next_cyc();
        do_ar(8'h33, 32'h0000_0020, 4'd0, 2'b01);
        rd_beat(14'h0008, 32'hFF34_FF78, 8'h33, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 responder that sits on one slave port (S0 or S1) of the AXI interconnect and backs it with a single-port synchronous SRAM macro.
- Accepts one read or one write burst at a time.
- Converts each beat to an SRAM access and returns R data or a B response on the AXI bus.

Parameters:
ID_W, 8, AWID/ARID/BID/RID width (interconnect-extended slave ID)
ADDR_W, 32, AXI address width
DATA_W, 32, data width; STRB = DATA_W/8
LEN_W, 4, burst length field width
MEM_AW, 14, SRAM word-address width

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESETn  in  1  synchronous active-low reset
AWID  in  ID_W  write ID
AWADDR  in  ADDR_W  write start byte address
AWLEN  in  LEN_W  beats-1
AWSIZE  in  3  ignored (word transfers only)
AWBURST  in  2  00 FIXED, otherwise INCR
AWVALID  in  1  |  AWREADY  out  1  write-address handshake
WDATA  in  DATA_W  write data
WSTRB  in  DATA_W/8  byte strobes
WLAST  in  1  last write beat
WVALID  in  1  |  WREADY  out  1  write-data handshake
BID  out  ID_W  response ID
BRESP  out  2  00 OKAY, 10 SLVERR
BVALID  out  1  |  BREADY  in  1  response handshake
ARID, ARADDR, ARLEN, ARSIZE, ARBURST  in  as AW*  read address fields
ARVALID  in  1  |  ARREADY  out  1  read-address handshake
RID  out  ID_W  |  RDATA  out  DATA_W  |  RRESP  out  2 (always 00)  |  RLAST  out  1
RVALID  out  1  |  RREADY  in  1  read-data handshake
CEB  out  1  SRAM chip enable, active low
WEB  out  1  SRAM write enable, active low (1 = read)
BWEB  out  DATA_W  SRAM bit write mask, active low
A  out  MEM_AW  SRAM word address = byte address[MEM_AW+1:2]
DI  out  DATA_W  SRAM write data
DO  in  DATA_W  SRAM read data; valid the cycle after a read, held while CEB=1

Behaviour:
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
- Reset (ARESETn=0 at an edge, including mid-burst): state=IDLE. AWREADY/WREADY/BVALID/ARREADY/RVALID/RLAST=0 in the reset cycle. CEB=1, WEB=1, BWEB=all 1. Latched ID/addr/len/beat counter/error flag cleared. Any in-flight burst is abandoned with no response.
- IDLE:
  - ARREADY=1.
  - AWREADY = ~ARVALID; reads win simultaneous requests.
  - AR handshake: latch ARID, ARADDR, ARLEN, ARBURST; beat=0; go to RD_REQ.
  - AW handshake: latch AW fields; beat=0; err=0; go to WR_DATA.
- RD_REQ: CEB=0, WEB=1, A=addr word index; go to RD_DATA. All AXI ready/valid outputs are 0.
- RD_DATA:
  - CEB=1; RVALID=1; RDATA=DO; RID=latched ID; RRESP=00; RLAST=(beat==len).
  - Outputs hold stable until RREADY.
  - On handshake: if last, go to IDLE; else beat+1, addr+=4 (unchanged if FIXED), go to RD_REQ.
  - Read latency: AR handshake in cycle N gives first RVALID in cycle N+2. Throughput is one beat per 2 cycles minimum.
- WR_DATA:
  - WREADY=1.
  - In the W handshake cycle: CEB=0, WEB=0, A=addr index, DI=WDATA, BWEB[8i+7:8i]=~{8{WSTRB[i]}}.
  - Outside a handshake, CEB=1.
  - If WLAST != (beat==len) on any beat, set sticky err.
  - After the handshake: if beat==len, go to WR_RESP; else beat+1, addr+=4 (unchanged if FIXED).
  - The burst always ends on the beat count, never on WLAST.
- WR_RESP: BVALID=1, BID=latched ID, BRESP = err ? 10 : 00; on BREADY go to IDLE.
- Address arithmetic: addr increments modulo 2^ADDR_W; A wraps modulo 2^MEM_AW. ADDR[1:0] and xSIZE are ignored. WRAP bursts are treated as INCR.
- No outstanding-transaction support: ARREADY=AWREADY=0 outside IDLE.

Test Plan:
- Single write then read: AW addr 0x0000_0010, len 0, WDATA 0xDEADBEEF, WSTRB 1111, WLAST=1. Expect a write to SRAM A=4 and BRESP 00 with BID echoed. Then AR addr 0x10, len 0 -> RVALID 2 cycles after AR handshake, RDATA 0xDEADBEEF, RLAST=1.
- INCR burst of 4: AW 0x100, len 3, data 1..4 -> SRAM A=0x40..0x43. AR 0x100, len 3 with RREADY toggling 1,0,1 -> RDATA 1..4 held across stalls, RLAST only on the 4th beat.
- Byte strobes: preload 0xFFFFFFFF at 0x20, write 0x12345678 with WSTRB 0101 -> read returns 0xFF34FF78.
- Simultaneous ARVALID/AWVALID in IDLE: AR accepted first (AWREADY=0). AW is accepted in the first IDLE cycle after the last RREADY handshake.
- WLAST error: len 1 with WLAST=1 on beat 0 -> both beats are still written and BRESP=10. FIXED burst len 2 to 0x40 -> all three beats go to A=0x10.
- Reset mid-burst: assert ARESETn=0 for 1 cycle during RD_DATA beat 1 of 4 -> next cycle RVALID=0, ARREADY=1, no further R beats, and a new read completes normally.
